// File: rtl/blockade_rom_loader_if.sv
// Download-side and ROM-write-side signals between the HPS ioctl port, the loader and the core.
// Handshake: ioctl_wr and dn_wr are single-cycle valid strobes with an implicit, always-asserted ready;
// a byte is transferred on every rising edge where the strobe is 1, and nothing can stall it.
interface blockade_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output dn_addr, dn_data, dn_wr
  );
endinterface

// File: rtl/blockade_rom_loader.sv
// Forwards ioctl ROM bytes to the blockade core, validates the image size and checksum,
// latches the game-mode byte and keeps the core in reset until a complete image is resident.
module blockade_rom_loader #(
  parameter int         ROM_BYTES  = 16384,
  parameter logic [7:0] ROM_INDEX  = 8'd0,
  parameter logic [7:0] MODE_INDEX = 8'd1,
  parameter int         RESET_HOLD = 16
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  blockade_rom_loader_if.slave        bus,
  output logic                        core_reset,
  output logic [1:0]                  game_mode,
  output logic                        rom_loaded,
  output logic                        rom_error,
  output logic [14:0]                 byte_count,
  output logic [7:0]                  checksum,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_LOAD  = 3'd1,
    S_MODE  = 3'd2,
    S_CHECK = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam int          HOLD_W     = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);
  localparam logic [24:0] ROM_LIMIT  = 25'(ROM_BYTES);
  localparam logic [14:0] ROM_COUNT  = 15'(ROM_BYTES);
  localparam logic [14:0] COUNT_MAX  = '1;

  state_t            cur;
  state_t            nxt;
  logic              overflow;
  logic [HOLD_W-1:0] hold_cnt;

  logic rom_start;
  logic mode_start;
  logic addr_in_range;
  logic image_ok;
  logic hold_done;
  logic load_entry;
  logic check_pass;
  logic check_fail;

  assign rom_start     = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign mode_start    = bus.ioctl_download && (bus.ioctl_index == MODE_INDEX);
  assign addr_in_range = bus.ioctl_addr < ROM_LIMIT;
  assign image_ok      = (byte_count == ROM_COUNT) && !overflow;
  assign hold_done     = hold_cnt == HOLD_LAST;
  assign load_entry    = (nxt == S_LOAD) && (cur != S_LOAD);
  assign check_pass    = (cur == S_CHECK) && (nxt == S_HOLD);
  assign check_fail    = (cur == S_CHECK) && (nxt == S_ERROR);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) cur <= S_EMPTY;
    else          cur <= nxt;
  end

  // A fresh ROM download pre-empts every settled state; MODE and LOAD must run to their own end.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_EMPTY, S_DONE, S_ERROR: begin
        if (rom_start)       nxt = S_LOAD;
        else if (mode_start) nxt = S_MODE;
      end
      S_LOAD: begin
        if (!bus.ioctl_download) nxt = S_CHECK;
      end
      S_MODE: begin
        if (!bus.ioctl_download) begin
          if (rom_loaded)     nxt = S_HOLD;
          else if (rom_error) nxt = S_ERROR;
          else                nxt = S_EMPTY;
        end
      end
      S_CHECK: begin
        if (rom_start)     nxt = S_LOAD;
        else if (image_ok) nxt = S_HOLD;
        else               nxt = S_ERROR;
      end
      S_HOLD: begin
        if (rom_start)      nxt = S_LOAD;
        else if (hold_done) nxt = S_DONE;
      end
      default: nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    core_reset = (cur != S_DONE);
    state      = cur;
  end

  // Writes in LOAD are taken regardless of ioctl_download so the strobe on the falling cycle lands.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.dn_wr   <= 1'b0;
      bus.dn_addr <= '0;
      bus.dn_data <= '0;
      byte_count  <= '0;
      checksum    <= '0;
      overflow    <= 1'b0;
      rom_loaded  <= 1'b0;
      rom_error   <= 1'b0;
      game_mode   <= '0;
      hold_cnt    <= '0;
    end else begin
      bus.dn_wr <= 1'b0;

      if (load_entry) begin
        byte_count <= '0;
        checksum   <= '0;
        overflow   <= 1'b0;
        rom_loaded <= 1'b0;
        rom_error  <= 1'b0;
      end

      if ((cur == S_LOAD) && bus.ioctl_wr) begin
        if (addr_in_range) begin
          bus.dn_wr   <= 1'b1;
          bus.dn_addr <= bus.ioctl_addr[13:0];
          bus.dn_data <= bus.ioctl_dout;
          if (byte_count != COUNT_MAX) byte_count <= byte_count + 15'd1;
          checksum <= checksum + bus.ioctl_dout;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (check_pass) rom_loaded <= 1'b1;
      if (check_fail) rom_error  <= 1'b1;

      if ((cur == S_MODE) && bus.ioctl_wr && (bus.ioctl_addr == '0))
        game_mode <= bus.ioctl_dout[1:0];

      hold_cnt <= (cur == S_HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_blockade_rom_loader.sv
// Scoreboarded bench for blockade_rom_loader: random ROM images, mode downloads, short/long loads and resets.
module tb_blockade_rom_loader;
  localparam int          ROM_BYTES  = 16384;
  localparam logic [7:0]  ROM_IDX    = 8'd0;
  localparam logic [7:0]  MODE_IDX   = 8'd1;
  localparam int          RESET_HOLD = 16;
  localparam int          W          = 54;

  localparam logic [2:0] ST_EMPTY = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MODE  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  blockade_rom_loader_if bus();
  logic        core_reset;
  logic [1:0]  game_mode;
  logic        rom_loaded;
  logic        rom_error;
  logic [14:0] byte_count;
  logic [7:0]  checksum;
  logic [2:0]  state;

  blockade_rom_loader #(
    .ROM_BYTES (ROM_BYTES),
    .ROM_INDEX (ROM_IDX),
    .MODE_INDEX(MODE_IDX),
    .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (bus),
    .core_reset(core_reset),
    .game_mode (game_mode),
    .rom_loaded(rom_loaded),
    .rom_error (rom_error),
    .byte_count(byte_count),
    .checksum  (checksum),
    .state     (state)
  );

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // Reference model of the loader's visible status
  int       m_count;
  int       m_sum;
  bit       m_ovf;
  bit       m_loaded;
  bit       m_error;
  bit [1:0] m_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every dn_wr must match the oldest outstanding accepted byte, exactly one cycle after its strobe.
  always @(negedge clk_sys) begin
    if (bus.dn_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL dn_unexpected: got write addr 0x%0h data 0x%0h expected none", bus.dn_addr, bus.dn_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dn_cycle", cyc, mon_e[53:22]);
        chk("dn_addr", {18'd0, bus.dn_addr}, {18'd0, mon_e[21:8]});
        chk("dn_data", {24'd0, bus.dn_data}, {24'd0, mon_e[7:0]});
      end
    end
  end

  task automatic drive(input bit dl, input logic [7:0] idx, input bit wr,
                       input logic [24:0] addr, input logic [7:0] data);
    @(negedge clk_sys);
    bus.ioctl_download = dl;
    bus.ioctl_index    = idx;
    bus.ioctl_wr       = wr;
    bus.ioctl_addr     = addr;
    bus.ioctl_dout     = data;
  endtask

  task automatic start_rom();
    drive(1'b1, ROM_IDX, 1'b0, '0, '0);
    m_count  = 0;
    m_sum    = 0;
    m_ovf    = 0;
    m_loaded = 0;
    m_error  = 0;
  endtask

  task automatic rom_byte(input logic [24:0] addr, input logic [7:0] data, input bit last);
    drive(!last, ROM_IDX, 1'b1, addr, data);
    if (addr < 25'(ROM_BYTES)) begin
      exp_q.push_back({32'(cyc + 1), addr[13:0], data});
      if (m_count < 32767) m_count++;
      m_sum = (m_sum + int'(data)) % 256;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic finish_rom_model();
    m_loaded = (m_count == ROM_BYTES) && !m_ovf;
    m_error  = !m_loaded;
  endtask

  task automatic mode_byte(input logic [24:0] addr, input logic [7:0] data);
    drive(1'b1, MODE_IDX, 1'b1, addr, data);
    if (addr == 0) m_mode = data[1:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, ROM_IDX, 1'b0, '0, '0);
  endtask

  // Called right after the cycle where download was driven low; counts edges to core_reset release.
  task automatic measure_release(input string name, input int exp_edges);
    int found = -1;
    int loaded_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      drive(1'b0, ROM_IDX, 1'b0, '0, '0);
      if (k > 2 && rom_loaded !== m_loaded) loaded_bad++;
      if (core_reset === 1'b0) begin
        found = k;
        break;
      end
    end
    chk({name, ".release_edges"}, found, exp_edges);
    chk({name, ".rom_loaded_stable"}, loaded_bad, 0);
  endtask

  task automatic check_status(input string tag, input logic [2:0] exp_state);
    chk({tag, ".state"},      {29'd0, state},      {29'd0, exp_state});
    chk({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, exp_state != ST_DONE});
    chk({tag, ".rom_loaded"}, {31'd0, rom_loaded}, {31'd0, m_loaded});
    chk({tag, ".rom_error"},  {31'd0, rom_error},  {31'd0, m_error});
    chk({tag, ".byte_count"}, {17'd0, byte_count}, m_count);
    chk({tag, ".checksum"},   {24'd0, checksum},   m_sum);
    chk({tag, ".game_mode"},  {30'd0, game_mode},  {30'd0, m_mode});
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;
    m_count = 0; m_sum = 0; m_ovf = 0; m_loaded = 0; m_error = 0; m_mode = 0;

    repeat (3) @(negedge clk_sys);
    check_status("reset", ST_EMPTY);
    chk("reset.dn_wr", {31'd0, bus.dn_wr}, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Full image with data = addr[7:0]
    start_rom();
    for (int i = 0; i < ROM_BYTES; i++) rom_byte(25'(i), 8'(i), 1'b0);
    drive(1'b0, ROM_IDX, 1'b0, '0, '0);
    finish_rom_model();
    measure_release("full", 18);
    check_status("full", ST_DONE);
    chk("full.checksum_zero", {24'd0, checksum}, 0);

    // Mode download from DONE
    drive(1'b1, MODE_IDX, 1'b0, '0, '0);
    mode_byte(25'd0, 8'h03);
    mode_byte(25'd1, 8'h01);
    drive(1'b1, MODE_IDX, 1'b0, '0, '0);
    check_status("mode_window", ST_MODE);
    drive(1'b0, MODE_IDX, 1'b0, '0, '0);
    measure_release("mode", 17);
    check_status("mode", ST_DONE);

    // Reload from DONE, then cut it short
    start_rom();
    drive(1'b1, ROM_IDX, 1'b0, '0, '0);
    check_status("reload", ST_LOAD);
    for (int i = 0; i < 100; i++) rom_byte(25'(i), 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b0, ROM_IDX, 1'b0, '0, '0);
    finish_rom_model();
    idle(3);
    check_status("short", ST_ERROR);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (core_reset !== 1'b1) lows++;
    end
    chk("short.core_reset_low_cycles", lows, 0);

    // Mode download from ERROR returns to ERROR
    drive(1'b1, MODE_IDX, 1'b0, '0, '0);
    mode_byte(25'd0, 8'h02);
    mode_byte(25'd5, 8'h01);
    drive(1'b0, MODE_IDX, 1'b0, '0, '0);
    idle(3);
    check_status("mode_err", ST_ERROR);

    // Full image plus one out-of-range byte
    start_rom();
    for (int i = 0; i < ROM_BYTES; i++) rom_byte(25'(i), 8'($urandom_range(0, 255)), 1'b0);
    rom_byte(25'(ROM_BYTES), 8'hAA, 1'b0);
    drive(1'b0, ROM_IDX, 1'b0, '0, '0);
    finish_rom_model();
    idle(3);
    check_status("overflow", ST_ERROR);

    // Reset in the middle of a load
    start_rom();
    for (int i = 0; i < 5000; i++) rom_byte(25'(i), 8'($urandom_range(0, 255)), 1'b0);
    @(negedge clk_sys);
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    @(negedge clk_sys);
    m_count = 0; m_sum = 0; m_ovf = 0; m_loaded = 0; m_error = 0; m_mode = 0;
    check_status("midreset", ST_EMPTY);
    reset_n = 1'b1;

    // Random full image with idle gaps; last byte arrives on the falling cycle
    start_rom();
    for (int i = 0; i < ROM_BYTES; i++) begin
      rom_byte(25'(i), 8'($urandom_range(0, 255)), i == ROM_BYTES - 1);
      if (i != ROM_BYTES - 1 && $urandom_range(0, 3) == 0) drive(1'b1, ROM_IDX, 1'b0, '0, '0);
    end
    finish_rom_model();
    measure_release("final", 18);
    check_status("final", ST_DONE);

    idle(3);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/blockade_rom_loader.md
# blockade_rom_loader

Loader between the HPS/sim `ioctl` download port and the `blockade` core's `dn_*` ROM write port. It forwards ROM bytes to the core with one registered stage and counts them against the expected image size. It keeps a running checksum, latches the game-mode byte from a separate download index, and holds the core in reset until a complete ROM image has landed. It replaces ad-hoc "rom_downloaded" latching at the top level.

## Interface
- `ROM_BYTES`, default 16384: exact image size required for a valid load.
- `ROM_INDEX`, default 8'd0: `ioctl_index` value carrying ROM data.
- `MODE_INDEX`, default 8'd1: `ioctl_index` value carrying the game-mode byte.
- `RESET_HOLD`, default 16: cycles `core_reset` stays high after any download ends in DONE.

Ports:
- `clk_sys` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ioctl_download` in 1: download window active.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 25: byte address within the current download.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: download target selector.
- `dn_addr` out 14: ROM write address to the core.
- `dn_data` out 8: ROM write data to the core.
- `dn_wr` out 1: one-cycle ROM write strobe to the core.
- `core_reset` out 1: active-high reset to the core.
- `game_mode` out 2: latched game select (0 Blockade, 1 Comotion, 2 Hustle, 3 Blasto).
- `rom_loaded` out 1: a valid full image is resident.
- `rom_error` out 1: the last ROM download was short, long or out of range.
- `byte_count` out 15: ROM bytes accepted in the current or last ROM download.
- `checksum` out 8: modulo-256 sum of the accepted ROM bytes.

## Operation
- FSM states: EMPTY, LOAD, MODE, CHECK, HOLD, DONE, ERROR.
- Reset (`reset_n`=0 at clock edge):
  - state goes to EMPTY.
  - All outputs go to 0, except `core_reset`, which goes to 1.
  - The overflow flag and hold counter clear.
- Entry into LOAD, from any state except LOAD/MODE:
  - Trigger: `ioctl_download`=1 with `ioctl_index`==ROM_INDEX.
  - Clear `byte_count`, `checksum`, the overflow flag, `rom_loaded` and `rom_error`.
- Entry into MODE, from EMPTY/DONE/ERROR:
  - Trigger: `ioctl_download`=1 with `ioctl_index`==MODE_INDEX.
  - ROM status is untouched.
- Write handling in LOAD, on `ioctl_wr`=1:
  - If `ioctl_addr` < ROM_BYTES: drive `dn_addr`=addr[13:0], `dn_data`=dout, `dn_wr`=1 for one cycle. Also `byte_count`+=1 and `checksum`+=dout (wraps mod 256).
  - Otherwise: set the overflow flag and drive no `dn_wr`.
- Write handling in MODE: `ioctl_wr` with addr==0 latches `game_mode`=dout[1:0]. Other addresses are ignored.
- LOAD exit: `ioctl_download` falls → CHECK. CHECK lasts one cycle:
  - `byte_count`==ROM_BYTES and no overflow → HOLD.
  - Otherwise → ERROR, with `rom_error`=1.
- MODE exit: `ioctl_download` falls → HOLD if `rom_loaded`, otherwise back to the prior EMPTY/ERROR.
- HOLD: count RESET_HOLD cycles, then go to DONE. `rom_loaded`=1 from CHECK success onward.
- `core_reset`=0 only in DONE; it is 1 in every other state.
- `ioctl_wr` outside LOAD/MODE is ignored.
- `byte_count` saturates at 2^15−1.
- Duplicate addresses are counted as separate bytes and written again.

## Timing
- `dn_wr`/`dn_addr`/`dn_data` are registered: one cycle after the `ioctl_wr` edge.
- `dn_addr`/`dn_data` hold their last values when `dn_wr`=0.
- A write strobe in the same cycle that `ioctl_download` falls is still accepted.
- CHECK evaluates in the cycle after the fall, after any final `byte_count` update.
- From the `ioctl_download` fall to `core_reset` fall: 1 (CHECK) + RESET_HOLD + 1 cycles, which is 18 by default.
- A new ROM download during HOLD or DONE:
  - `core_reset` rises on the next edge.
  - `rom_loaded` clears on that same edge.
- Back-to-back `ioctl_wr` every cycle is supported; there is no backpressure.
- `game_mode` changes take effect only inside a download window. The core always sees them under reset.

## Test plan
- Load 16384 bytes of data=addr[7:0] at addr 0..16383, then drop download.
  - `dn_wr` pulses 16384 times, each one cycle after its `ioctl_wr`.
  - `checksum`=0x00, `byte_count`=16384, `rom_error`=0, `rom_loaded`=1.
  - `core_reset` falls exactly 18 cycles after the download fall.
- Load only 100 bytes, then drop download → ERROR, `rom_error`=1, `rom_loaded`=0, `core_reset` stays 1.
- Full load plus one write at addr 16384 → no `dn_wr` for that byte, overflow recorded, ERROR, `rom_error`=1.
- After DONE, run a MODE download with byte 0x03 at addr 0 and 0x01 at addr 1:
  - `game_mode`=3.
  - `core_reset` is high during the window and for 17 cycles after, then low.
  - `rom_loaded` stays 1 throughout.
- Pull `reset_n` low mid-LOAD at byte 5000 → next edge shows state EMPTY, `byte_count`=0, `game_mode`=0, `core_reset`=1. A subsequent full load succeeds.
- Start a ROM reload while in DONE → `core_reset`=1 and `rom_loaded`=0 on the next edge; the counters clear.
